// File: rtl/dcache_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_arb_pkg
// Description : Shared types and constants for the Dcache port arbiter.
//               State encoding of the serialising FSM, byte-select width,
//               the all-bytes select used for reads and the owner encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_arb_pkg;

    localparam int          WSEL_W     = 4;
    localparam logic [3:0]  RD_SEL_ALL = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/dcache_port_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Combinational two-way round-robin pick. A sole requester
//               always wins; on a tie the requester named by i_prio wins.
//               The priority register itself lives in the parent.
// Ports       : i_req0, i_req1  request lines
//               i_prio          tie-break owner (0 = req0, 1 = req1)
//               o_valid         at least one request present
//               o_winner        selected requester (0 = req0, 1 = req1)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_prio,
    output logic o_valid,
    output logic o_winner
);

    assign o_valid  = i_req0 | i_req1;
    // With both requesting, prio decides; otherwise whichever is asserting.
    assign o_winner = (i_req0 & i_req1) ? i_prio : i_req1;

endmodule
`default_nettype wire

// File: rtl/dcache_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dcache_port_arbiter
// Description : Shares one Dcache access port between m0 (load/store unit)
//               and m1 (test driver / refill engine). One transaction at a
//               time, round-robin priority, registered Dcache strobes and
//               address/data, read data returned after RD_LAT non-stalled
//               cycles.
// Ports       : clk, rst                 clock, synchronous active-high reset
//               m{0,1}_req/we/addr/wdata/wsel   requester inputs
//               m{0,1}_gnt               one-cycle accept pulse
//               m{0,1}_rvalid/rdata      read response
//               dcache_data_i, dcache_stall_i  Dcache read data and busy
//               dcache_raddr_o/waddr_o/wdata_o/wsel_o/wreq_o/rreq_o
//                                        registered Dcache request
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_port_arbiter
    import dcache_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [WSEL_W-1:0] m0_wsel,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [WSEL_W-1:0] m1_wsel,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    input  logic [DATA_W-1:0] dcache_data_i,
    input  logic              dcache_stall_i,
    output logic [ADDR_W-1:0] dcache_raddr_o,
    output logic [ADDR_W-1:0] dcache_waddr_o,
    output logic [DATA_W-1:0] dcache_wdata_o,
    output logic              dcache_wreq_o,
    output logic              dcache_rreq_o,
    output logic [WSEL_W-1:0] dcache_wsel_o
);

    localparam logic [2:0] LAT_LOAD = RD_LAT[2:0];

    state_t      r_state;
    state_t      w_state_nxt;
    owner_t      r_owner;
    logic        r_we;
    logic        r_prio;
    logic [2:0]  r_cnt;

    logic        w_valid;
    logic        w_winner;
    logic        w_accept;   // ISSUE cycle not stalled: Dcache takes the request
    logic        w_sample;   // last WAIT cycle: capture dcache_data_i

    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic [WSEL_W-1:0] w_sel_wsel;

    rr_arb2 u_rr_arb2 (
        .i_req0   (m0_req),
        .i_req1   (m1_req),
        .i_prio   (r_prio),
        .o_valid  (w_valid),
        .o_winner (w_winner)
    );

    assign w_sel_we    = w_winner ? m1_we    : m0_we;
    assign w_sel_addr  = w_winner ? m1_addr  : m0_addr;
    assign w_sel_wdata = w_winner ? m1_wdata : m0_wdata;
    assign w_sel_wsel  = w_winner ? m1_wsel  : m0_wsel;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and handshake strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_sample    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (!dcache_stall_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = r_we ? IDLE : WAIT;
                end
            end
            WAIT: begin
                // Counter still holds 1 in the cycle it is about to reach 0.
                if (!dcache_stall_i && (r_cnt == 3'd1)) begin
                    w_sample    = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign m0_gnt    = w_accept && (r_owner == M0);
    assign m1_gnt    = w_accept && (r_owner == M1);
    assign m0_rvalid = (r_state == RESP) && (r_owner == M0);
    assign m1_rvalid = (r_state == RESP) && (r_owner == M1);

    // ------------------------------------------------------------------
    // Datapath: latched transaction, Dcache request registers, response
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner        <= M0;
            r_we           <= 1'b0;
            r_prio         <= 1'b0;
            r_cnt          <= 3'd0;
            dcache_raddr_o <= '0;
            dcache_waddr_o <= '0;
            dcache_wdata_o <= '0;
            dcache_wsel_o  <= '0;
            dcache_wreq_o  <= 1'b0;
            dcache_rreq_o  <= 1'b0;
            m0_rdata       <= '0;
            m1_rdata       <= '0;
        end else begin
            if ((r_state == IDLE) && w_valid) begin
                r_owner <= owner_t'(w_winner);
                r_we    <= w_sel_we;
                if (w_sel_we) begin
                    dcache_wreq_o  <= 1'b1;
                    dcache_waddr_o <= w_sel_addr;
                    dcache_wdata_o <= w_sel_wdata;
                    dcache_wsel_o  <= w_sel_wsel;
                end else begin
                    dcache_rreq_o  <= 1'b1;
                    dcache_raddr_o <= w_sel_addr;
                    dcache_wsel_o  <= RD_SEL_ALL;
                end
            end

            if (w_accept) begin
                dcache_wreq_o <= 1'b0;
                dcache_rreq_o <= 1'b0;
                r_prio        <= ~r_owner;
                if (!r_we) begin
                    r_cnt <= LAT_LOAD;
                end
            end

            if ((r_state == WAIT) && !dcache_stall_i) begin
                r_cnt <= r_cnt - 3'd1;
            end

            if (w_sample) begin
                if (r_owner == M0) begin
                    m0_rdata <= dcache_data_i;
                end else begin
                    m1_rdata <= dcache_data_i;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Shares the single Dcache access port between two requesters: m0 (load/store unit) and m1 (test driver / refill engine).
- Serialises one transaction at a time and uses round-robin priority.
- Drives the Dcache read/write request signals as registered outputs.
- Returns read data to the owning requester after a fixed read latency, extended by Dcache stall cycles.

Parameters:
- ADDR_W, 32, address width of requesters and Dcache
- DATA_W, 32, data width
- RD_LAT, 1, non-stalled cycles from read acceptance to valid dcache_data_i (legal 1..7)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- m0_req  in  1  m0 request; held with its fields until m0_gnt
- m0_we  in  1  1 = write, 0 = read
- m0_addr  in  ADDR_W  m0 address
- m0_wdata  in  DATA_W  m0 write data
- m0_wsel  in  4  m0 byte enables
- m0_gnt  out  1  one-cycle pulse: request accepted by Dcache
- m0_rvalid  out  1  one-cycle pulse: m0_rdata valid
- m0_rdata  out  DATA_W  read data for m0
- m1_req, m1_we, m1_addr, m1_wdata, m1_wsel, m1_gnt, m1_rvalid, m1_rdata: identical set for m1
- dcache_data_i  in  DATA_W  Dcache read data
- dcache_stall_i  in  1  Dcache busy (miss/refill); freezes the arbiter
- dcache_raddr_o  out  ADDR_W  read address
- dcache_waddr_o  out  ADDR_W  write address
- dcache_wdata_o  out  DATA_W  write data
- dcache_wreq_o  out  1  write request
- dcache_rreq_o  out  1  read request
- dcache_wsel_o  out  4  byte select

Behaviour:
- Reset (rst=1 at posedge):
  - All outputs are 0.
  - State is IDLE, prio=0 (m0 favoured), latency counter is 0.
  - Any in-flight read is dropped; no rvalid is produced for it.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, pick the winner: the sole requester, or on a tie the one indicated by prio.
  - Latch owner, we, addr, wdata and wsel.
  - Load the dcache_* outputs: wreq_o or rreq_o = 1. For a write, waddr/wdata/wsel come from the requester. For a read, raddr comes from the requester and wsel_o = 4'b1111.
  - Next state is ISSUE.
- ISSUE:
  - Request signals stay high.
  - If dcache_stall_i=1: hold everything, no gnt.
  - Otherwise: owner's gnt=1 for this cycle only, prio := the other requester, wreq_o/rreq_o cleared at the end of the cycle.
  - Next state: write → IDLE; read → WAIT with counter=RD_LAT.
- Requester protocol: the requester samples gnt at the posedge and may drop req or present a new request from the next cycle.
- WAIT:
  - Counter decrements each cycle in which dcache_stall_i=0.
  - When it reaches 0, sample dcache_data_i into the owner's rdata and go to RESP.
- RESP:
  - Owner's rvalid=1 for one cycle; go to IDLE.
  - rdata holds its value until the next read to that requester completes.
- Timing:
  - Write: req seen in cycle T, gnt in T+1, next arbitration in T+2.
  - Read (RD_LAT=1, no stall): gnt in T+1, data sampled at end of T+2, rvalid in T+3.
- dcache address/data outputs hold their last values when idle. The request strobes are never high outside ISSUE.
- Requests are never reordered and never more than one is outstanding. A request arriving during a busy period waits in IDLE arbitration.
- Non-owner gnt and rvalid are always 0. gnt and rvalid are never high for both requesters in the same cycle.
- If a requester drops req before gnt after being latched, the transaction still completes. This is a protocol violation; the bench flags it.

Decomposition:
- Package dcache_arb_pkg: state enum (IDLE, ISSUE, WAIT, RESP), WSEL_W=4, RD_SEL_ALL=4'b1111, owner encoding (M0=0, M1=1).
- Sub-module rr_arb2: combinational two-way round-robin pick from (req0, req1, prio) → (valid, winner). The top level holds the prio register.

Test Plan:
- Single write: m0 write addr=5, data=32'h1234, wsel=4'hF → dcache_wreq_o=1 and m0_gnt=1 in the same cycle, waddr_o=5, wdata_o=32'h1234; nothing on m1.
- Write then read back: m1 write addr=3 data=32'hBEEF, then read addr=3. The Dcache model returns 32'hBEEF one cycle after rreq → m1_rvalid pulses 3 cycles after the read req, m1_rdata=32'hBEEF, rreq_o width exactly 1 cycle.
- Contention: m0 and m1 both request reads from reset → m0 granted first, then m1; with both held continuously, grants alternate m0, m1, m0, m1 over 8 transactions.
- Stall: dcache_stall_i=1 for 4 cycles during ISSUE of m0 write addr=7 → rreq/wreq held 5 cycles, m0_gnt pulses only in the first non-stall cycle. A stall of 2 cycles during WAIT delays rvalid by exactly 2 cycles.
- Reset mid-read: assert rst in WAIT of an m1 read addr=9 → all outputs 0 the next cycle, no m1_rvalid ever produced, prio=0.
- Randomised consistency: 16 random words written to addr 0..15 alternately via m0/m1, then read back via the opposite requester → all 16 match, and no gnt/rvalid overlap is detected.
